fec_chain_controller: RTL

- Parametrised successor to the fixed encoder/modulator FEC controller.
- Sequences a frame of BLOCK_LEN words from a buffer through a chain of NUM_STAGES processing stages (e.g. encoder → modulator, or demodulator → decoder), using per-stage req/ack handshakes.
- Adds a per-word timeout watchdog, a sticky error flag, abort-on-disable and a frame-done ack.
- Sits between the sample/bit buffer and the FEC datapath stages.

---
 rtl/fec_chain_controller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/fec_chain_controller.sv
// fec_chain_controller
//   Sequences a frame of BLOCK_LEN words from the sample/bit buffer through a
//   chain of NUM_STAGES FEC datapath stages. Each word goes through these steps:
//   a buffer read strobe, a wait for read-valid, then a req/ack handshake with
//   each stage in order. A per-step watchdog raises a sticky error if the
//   buffer or a stage stalls for TIMEOUT cycles. Dropping en aborts the frame.
//
//   Optional feature macro: FEC_STAGE_BYPASS_EN
//     When defined, adds the bypass_mask input. The mask is sampled at frame
//     start. Masked stages keep stage_en low and are skipped with zero cycles.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   en             block enable, low aborts any frame in progress
//   req            start-frame request (level, only looked at in IDLE)
//   buff_empty     source buffer empty
//   buff_rd_valid  buffer read data valid
//   stage_ack      per-stage acknowledge
//   bypass_mask    per-stage bypass (only with FEC_STAGE_BYPASS_EN)
//   rd_en_buff     one-cycle buffer read strobe
//   stage_req      per-stage request, one-hot or zero
//   stage_en       per-stage enable, high for the whole frame
//   ack            one-cycle frame-complete pulse
//   busy           high while a frame is in flight
//   err            sticky timeout error
//   word_cnt       words completed in the current (or last) frame
module fec_chain_controller #(
  parameter int NUM_STAGES = 2,
  parameter int BLOCK_LEN  = 16,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = $clog2(BLOCK_LEN + 1),
  parameter int TO_W       = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  req,
  input  logic                  buff_empty,
  input  logic                  buff_rd_valid,
  input  logic [NUM_STAGES-1:0] stage_ack,
`ifdef FEC_STAGE_BYPASS_EN
  input  logic [NUM_STAGES-1:0] bypass_mask,
`endif
  output logic                  rd_en_buff,
  output logic [NUM_STAGES-1:0] stage_req,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  ack,
  output logic                  busy,
  output logic                  err,
  output logic [CNT_W-1:0]      word_cnt
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, STAGE, DONE, ERROR} state_t;

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  state_t                state;
  logic [SW-1:0]         stage_idx;
  logic [TO_W-1:0]       to_cnt;
  logic [NUM_STAGES-1:0] start_mask;
  logic [NUM_STAGES-1:0] first_oh;
  logic [NUM_STAGES-1:0] next_oh;
  logic [SW-1:0]         first_idx;
  logic [SW-1:0]         next_idx;
  logic                  progress;

  // Returns a one-hot vector for the lowest active stage at or above 'start'.
  // Returns zero if no such stage exists.
  function automatic logic [NUM_STAGES-1:0] first_active(
    input logic [NUM_STAGES-1:0] active,
    input int                    start
  );
    logic [NUM_STAGES-1:0] oh;
    oh = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i >= start && active[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [SW-1:0] oh_index(input logic [NUM_STAGES-1:0] oh);
    logic [SW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (oh[i]) idx = SW'(i);
    end
    return idx;
  endfunction

`ifdef FEC_STAGE_BYPASS_EN
  assign start_mask = ~bypass_mask;
`else
  assign start_mask = '1;
`endif

  // stage_en holds the active-stage set for the whole frame. It also drives the
  // skip logic. A frame with every stage bypassed finds no first stage, so each
  // word then completes directly from WAIT_RD.
  // progress means the condition the current state is waiting on has arrived.
  // This condition beats the watchdog in the same cycle.
  always_comb begin
    first_oh  = first_active(stage_en, 0);
    next_oh   = first_active(stage_en, int'(stage_idx) + 1);
    first_idx = oh_index(first_oh);
    next_idx  = oh_index(next_oh);
    progress  = 1'b0;
    case (state)
      FETCH:   progress = !buff_empty;
      WAIT_RD: progress = buff_rd_valid;
      STAGE:   progress = stage_ack[stage_idx];
      default: progress = 1'b0;
    endcase
  end

  // Main sequencer. All outputs are registered here, and each is assigned
  // together with the state it belongs to.
  // Abort on !en takes priority over everything except reset. It leaves
  // word_cnt and err untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stage_idx  <= '0;
      to_cnt     <= '0;
      word_cnt   <= '0;
      rd_en_buff <= 1'b0;
      stage_req  <= '0;
      stage_en   <= '0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rd_en_buff <= 1'b0;
      ack        <= 1'b0;
      if (state != IDLE && !en) begin
        state     <= IDLE;
        stage_req <= '0;
        stage_en  <= '0;
        busy      <= 1'b0;
        stage_idx <= '0;
        to_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (en && req) begin
              state     <= FETCH;
              word_cnt  <= '0;
              err       <= 1'b0;
              stage_en  <= start_mask;
              busy      <= 1'b1;
              stage_idx <= '0;
              to_cnt    <= '0;
            end
          end
          FETCH, WAIT_RD, STAGE: begin
            if (!progress) begin
              if (to_cnt == TO_LAST) begin
                state     <= ERROR;
                stage_req <= '0;
                stage_en  <= '0;
                busy      <= 1'b0;
                err       <= 1'b1;
                stage_idx <= '0;
                to_cnt    <= '0;
              end else begin
                to_cnt <= to_cnt + 1'b1;
              end
            end else begin
              to_cnt <= '0;
              if (state == FETCH) begin
                rd_en_buff <= 1'b1;
                state      <= WAIT_RD;
              end else if (state == WAIT_RD && |first_oh) begin
                state     <= STAGE;
                stage_req <= first_oh;
                stage_idx <= first_idx;
              end else if (state == STAGE && |next_oh) begin
                stage_req <= next_oh;
                stage_idx <= next_idx;
              end else begin
                // The last active stage has acknowledged, so this word is done.
                stage_req <= '0;
                stage_idx <= '0;
                word_cnt  <= word_cnt + 1'b1;
                state     <= (word_cnt == LAST_WORD) ? DONE : FETCH;
              end
            end
          end
          DONE: begin
            ack      <= 1'b1;
            stage_en <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          ERROR: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
